// File: rtl/bird_motion_pkg.sv
// Shared game constants and encodings for the bird motion logic.
package bird_motion_pkg;

    // Screen and sprite geometry (px)
    localparam int BIRD_X   = 200;
    localparam int START_Y  = 220;
    localparam int BIRD_H   = 24;
    localparam int GROUND_Y = 400;

    // Physics (px/tick)
    localparam int GRAVITY  = 1;
    localparam int FLAP_V   = 8;
    localparam int MAX_FALL = 10;

    // Sized forms used by the datapath
    localparam logic [9:0]         BIRD_X_C   = 10'(BIRD_X);
    localparam logic [8:0]         START_Y_C  = 9'(START_Y);
    localparam logic [8:0]         GROUND_LIM = 9'(GROUND_Y - BIRD_H);
    localparam logic signed [5:0]  FLAP_VEL   = -6'(FLAP_V);
    localparam logic signed [5:0]  GRAV_VEL   = 6'(GRAVITY);
    localparam logic signed [5:0]  MAX_VEL    = 6'(MAX_FALL);

    typedef enum logic [1:0] {
        MOT_IDLE  = 2'd0,
        MOT_FLY   = 2'd1,
        MOT_DYING = 2'd2,
        MOT_DEAD  = 2'd3
    } motion_t;

    // Gravity step with saturation at the terminal fall speed
    function automatic logic signed [5:0] fall_step(input logic signed [5:0] v);
        if (v >= MAX_VEL - GRAV_VEL)
            return MAX_VEL;
        else
            return v + GRAV_VEL;
    endfunction

endpackage

// File: rtl/bird_motion_edge_rise.sv
// Registered rising-edge detector: one-cycle pulse the cycle after in goes high.
module bird_motion_edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev_reg;
    logic pulse_reg;

    // Remember last level and register the rising-edge compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            prev_reg  <= in;
            pulse_reg <= in & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/bird_motion.sv
// Bird vertical physics: gravity/flap integration per frame tick,
// ceiling clamp, ground detection and collision-driven death sequence.
module bird_motion
    import bird_motion_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        playing,
    input  logic        flap,
    input  logic        collide,
    output logic [9:0]  x,
    output logic [8:0]  y,
    output logic [5:0]  vel,
    output logic [1:0]  motion_st,
    output logic        flapped,
    output logic        game_over
);

    motion_t            state_reg;
    logic [8:0]         y_reg;
    logic signed [5:0]  vel_reg;
    logic               flap_pend_reg;
    logic               coll_pend_reg;
    logic               flapped_reg;
    logic               game_over_reg;

    logic               flap_pulse;
    logic signed [10:0] sum;
    logic               hit_ground;
    logic               hit_ceiling;

    bird_motion_edge_rise u_flap_edge (
        .clk   (clk),
        .rst   (rst),
        .in    (flap),
        .pulse (flap_pulse)
    );

    // Candidate position for this tick; 11 bits so neither clamp can wrap
    always_comb begin
        sum         = $signed({2'b00, y_reg}) + $signed({{5{vel_reg[5]}}, vel_reg});
        hit_ground  = (sum >= $signed({2'b00, GROUND_LIM}));
        hit_ceiling = (sum < 11'sd0);
    end

    // Motion FSM and y/vel datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= MOT_IDLE;
            y_reg         <= START_Y_C;
            vel_reg       <= '0;
            flap_pend_reg <= 1'b0;
            coll_pend_reg <= 1'b0;
            flapped_reg   <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            flapped_reg   <= 1'b0;
            game_over_reg <= 1'b0;
            if (!playing) begin
                // Leaving play always wins over any tick action
                state_reg     <= MOT_IDLE;
                y_reg         <= START_Y_C;
                vel_reg       <= '0;
                flap_pend_reg <= 1'b0;
                coll_pend_reg <= 1'b0;
            end else begin
                case (state_reg)
                    MOT_IDLE: begin
                        state_reg     <= MOT_FLY;
                        y_reg         <= START_Y_C;
                        vel_reg       <= FLAP_VEL;
                        flapped_reg   <= 1'b1;
                        flap_pend_reg <= 1'b0;
                        coll_pend_reg <= 1'b0;
                    end
                    MOT_FLY: begin
                        if (collide)
                            coll_pend_reg <= 1'b1;
                        if (tick) begin
                            flap_pend_reg <= 1'b0;
                            if (coll_pend_reg) begin
                                // Collision wins: pending flap is dropped
                                state_reg     <= MOT_DYING;
                                coll_pend_reg <= 1'b0;
                            end else if (hit_ground) begin
                                state_reg     <= MOT_DEAD;
                                y_reg         <= GROUND_LIM;
                                vel_reg       <= '0;
                                game_over_reg <= 1'b1;
                            end else if (hit_ceiling) begin
                                y_reg   <= '0;
                                vel_reg <= '0;
                            end else begin
                                y_reg <= sum[8:0];
                                if (flap_pend_reg) begin
                                    vel_reg     <= FLAP_VEL;
                                    flapped_reg <= 1'b1;
                                end else begin
                                    vel_reg <= fall_step(vel_reg);
                                end
                            end
                        end
                        // A new edge arriving on a tick cycle survives for the next tick
                        if (flap_pulse)
                            flap_pend_reg <= 1'b1;
                    end
                    MOT_DYING: begin
                        flap_pend_reg <= 1'b0;
                        coll_pend_reg <= 1'b0;
                        if (tick) begin
                            if (hit_ground) begin
                                state_reg     <= MOT_DEAD;
                                y_reg         <= GROUND_LIM;
                                vel_reg       <= '0;
                                game_over_reg <= 1'b1;
                            end else if (hit_ceiling) begin
                                y_reg   <= '0;
                                vel_reg <= '0;
                            end else begin
                                y_reg   <= sum[8:0];
                                vel_reg <= fall_step(vel_reg);
                            end
                        end
                    end
                    default: begin
                        // DEAD: frozen until playing drops
                        flap_pend_reg <= 1'b0;
                        coll_pend_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign x         = BIRD_X_C;
    assign y         = y_reg;
    assign vel       = vel_reg;
    assign motion_st = state_reg;
    assign flapped   = flapped_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_bird_motion.sv
// Directed self-checking bench for bird_motion.
module tb_bird_motion;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       playing;
    logic       flap;
    logic       collide;
    logic [9:0] x;
    logic [8:0] y;
    logic [5:0] vel;
    logic [1:0] motion_st;
    logic       flapped;
    logic       game_over;

    int checks;
    int errors;

    bird_motion dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .playing   (playing),
        .flap      (flap),
        .collide   (collide),
        .x         (x),
        .y         (y),
        .vel       (vel),
        .motion_st (motion_st),
        .flapped   (flapped),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int ey, input int ev, input int est);
        check({tag, "_y"},   32'(y), ey);
        check({tag, "_vel"}, 32'($signed(vel)), ev);
        check({tag, "_st"},  32'(motion_st), est);
    endtask

    // One-cycle tick; returns on the negedge after it was applied
    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // One flap press; returns once the edge has reached the pending flag
    task automatic do_flap();
        flap = 1'b1;
        @(negedge clk);
        flap = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int  fl_cnt;
        int  go_cnt;
        bit  done;
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        tick    = 1'b0;
        playing = 1'b0;
        flap    = 1'b0;
        collide = 1'b0;

        // 1: reset state, start of flight
        @(negedge clk);
        check_pos("reset", 220, 0, 0);
        check("reset_x", 32'(x), 200);
        check("reset_flapped", 32'(flapped), 0);
        check("reset_go", 32'(game_over), 0);
        rst     = 1'b0;
        playing = 1'b1;
        @(negedge clk);
        check_pos("start", 220, -8, 1);
        check("start_flapped", 32'(flapped), 1);
        @(negedge clk);
        check("start_flapped_low", 32'(flapped), 0);
        do_tick();
        check_pos("tick1", 212, -7, 1);
        do_tick();
        check_pos("tick2", 205, -6, 1);
        $display("step1 start/first ticks y=%0d vel=%0d", y, $signed(vel));

        // 2: free fall to the ground
        repeat (15) do_tick();
        check_pos("fall15", 220, 9, 1);
        do_tick();
        check_pos("fall16", 229, 10, 1);
        do_tick();
        check_pos("fall17_sat", 239, 10, 1);
        repeat (13) do_tick();
        check_pos("fall30", 369, 10, 1);
        do_tick();
        check_pos("ground", 376, 0, 3);
        check("ground_go", 32'(game_over), 1);
        @(negedge clk);
        check("ground_go_low", 32'(game_over), 0);
        do_tick();
        check_pos("dead_frozen", 376, 0, 3);
        $display("step2 ground reached y=%0d st=%0d", y, motion_st);

        // 3: flap up to the ceiling
        playing = 1'b0;
        @(negedge clk);
        check_pos("idle", 220, 0, 0);
        playing = 1'b1;
        @(negedge clk);
        check_pos("restart", 220, -8, 1);
        do_flap();
        do_tick();
        check_pos("flap1", 212, -8, 1);
        check("flap1_flapped", 32'(flapped), 1);
        repeat (26) begin
            do_flap();
            do_tick();
        end
        check_pos("near_top", 4, -8, 1);
        do_tick();
        check_pos("ceiling", 0, 0, 1);
        check("ceiling_flapped", 32'(flapped), 0);
        do_tick();
        check_pos("ceiling_next", 0, 1, 1);
        $display("step3 ceiling clamp y=%0d vel=%0d", y, $signed(vel));

        // 4: collision together with a flap
        collide = 1'b1;
        flap    = 1'b1;
        @(negedge clk);
        collide = 1'b0;
        flap    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_tick();
        check("coll_st", 32'(motion_st), 2);
        check("coll_flapped", 32'(flapped), 0);
        fl_cnt = 0;
        go_cnt = 0;
        done   = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            do_flap();
            do_tick();
            fl_cnt += int'(flapped);
            go_cnt += int'(game_over);
            if (motion_st == 2'd3) done = 1'b1;
        end
        check("dying_reached_dead", 32'(done), 1);
        check("dying_no_flap", fl_cnt, 0);
        check("dying_go_count", go_cnt, 1);
        check_pos("dying_ground", 376, 0, 3);
        $display("step4 dying descent done=%0d flaps=%0d", done, fl_cnt);

        // 5: drop playing mid-air at y=150
        playing = 1'b0;
        @(negedge clk);
        playing = 1'b1;
        @(negedge clk);
        repeat (5) begin
            do_flap();
            do_tick();
        end
        check_pos("climb", 180, -8, 1);
        repeat (5) do_tick();
        check_pos("midair", 150, -3, 1);
        playing = 1'b0;
        @(negedge clk);
        check_pos("drop_idle", 220, 0, 0);
        do_tick();
        check_pos("idle_tick", 220, 0, 0);
        $display("step5 drop to idle y=%0d st=%0d", y, motion_st);

        // 6: async reset mid-DYING, then multiple flap edges
        playing = 1'b1;
        @(negedge clk);
        collide = 1'b1;
        @(negedge clk);
        collide = 1'b0;
        do_tick();
        check("pre_rst_dying", 32'(motion_st), 2);
        #2 rst = 1'b1;
        #1;
        check_pos("async_rst", 220, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_pos("after_rst", 220, -8, 1);
        @(negedge clk);
        repeat (3) begin
            flap = 1'b1;
            @(negedge clk);
            flap = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        fl_cnt = 0;
        do_tick();
        fl_cnt += int'(flapped);
        check_pos("multi_flap", 212, -8, 1);
        repeat (3) begin
            @(negedge clk);
            fl_cnt += int'(flapped);
        end
        do_tick();
        fl_cnt += int'(flapped);
        check_pos("multi_next", 204, -7, 1);
        check("multi_flap_count", fl_cnt, 1);
        $display("step6 reset/multi-flap flaps=%0d", fl_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
